// File: rtl/ep01_b.sv
// ep01_b: 4-input Boolean function unit with a registered copy, edge pulses and code coverage.
// Optional code coverage is enabled by defining EP01B_COVERAGE_EN.
module ep01_b #(
  parameter logic [15:0] TRUTH_TABLE = 16'h28AC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  output logic        f,
  output logic        f_q,
  output logic        f_rise,
  output logic        f_fall,
  output logic [15:0] seen_mask,
  output logic        all_seen
);

  logic [3:0] code_s;
  logic       f_s;
  logic       f_q_r;
  logic       f_rise_r;
  logic       f_fall_r;

  function automatic logic table_lookup(input logic [15:0] tt, input logic [3:0] idx);
    return tt[idx];
  endfunction

  assign code_s = {a, b, c, d};

  // Combinational table lookup; a is the code MSB.
  always_comb begin
    f_s = table_lookup(TRUTH_TABLE, code_s);
  end

  assign f = f_s;

  // Registered copy of f and one-cycle edge pulses aligned with the new f_q value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q_r    <= 1'b0;
      f_rise_r <= 1'b0;
      f_fall_r <= 1'b0;
    end else begin
      f_q_r    <= f_s;
      f_rise_r <= f_s & ~f_q_r;
      f_fall_r <= ~f_s & f_q_r;
    end
  end

  assign f_q    = f_q_r;
  assign f_rise = f_rise_r;
  assign f_fall = f_fall_r;

`ifdef EP01B_COVERAGE_EN
  logic [15:0] seen_mask_r;
  logic [15:0] mask_next_s;
  logic        all_seen_r;

  // Next coverage mask: sticky OR of the code sampled this edge.
  always_comb begin
    mask_next_s = seen_mask_r | (16'h0001 << code_s);
  end

  // all_seen is registered from the next mask so it moves in the same cycle as the mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_mask_r <= 16'h0000;
      all_seen_r  <= 1'b0;
    end else begin
      seen_mask_r <= mask_next_s;
      all_seen_r  <= &mask_next_s;
    end
  end

  assign seen_mask = seen_mask_r;
  assign all_seen  = all_seen_r;
`else
  assign seen_mask = 16'h0000;
  assign all_seen  = 1'b0;
`endif

endmodule

// File: tb/tb_ep01_b.sv
// Directed self-checking bench for ep01_b (default table plus a 16'h8001 override instance).
module tb_ep01_b;

  logic        clk;
  logic        rst;
  logic        a, b, c, d;
  logic        f, f_q, f_rise, f_fall, all_seen;
  logic [15:0] seen_mask;
  logic        f2, f2_q, f2_rise, f2_fall, all_seen2;
  logic [15:0] seen_mask2;

  int total;
  int bad;

  bit exp_prime [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  bit exp_ends  [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

`ifdef EP01B_COVERAGE_EN
  localparam logic [15:0] EXP_MASK_15 = 16'h7FFF;
  localparam logic [15:0] EXP_MASK_16 = 16'hFFFF;
  localparam logic        EXP_ALL_16  = 1'b1;
`else
  localparam logic [15:0] EXP_MASK_15 = 16'h0000;
  localparam logic [15:0] EXP_MASK_16 = 16'h0000;
  localparam logic        EXP_ALL_16  = 1'b0;
`endif

  ep01_b dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .f(f), .f_q(f_q), .f_rise(f_rise), .f_fall(f_fall),
    .seen_mask(seen_mask), .all_seen(all_seen)
  );

  ep01_b #(.TRUTH_TABLE(16'h8001)) dut_ends (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .f(f2), .f_q(f2_q), .f_rise(f2_rise), .f_fall(f2_fall),
    .seen_mask(seen_mask2), .all_seen(all_seen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_code(input logic [3:0] code);
    {a, b, c, d} = code;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_code(4'd0);
    #2;
    check_val("rst_f_q", {15'd0, f_q}, 16'd0);
    check_val("rst_pulses", {14'd0, f_rise, f_fall}, 16'd0);
    check_val("rst_mask", seen_mask, 16'h0000);
    check_val("rst_all_seen", {15'd0, all_seen}, 16'd0);
    check_val("rst_f2_q", {15'd0, f2_q}, 16'd0);

    // exhaustive combinational sweep while held in reset
    for (int k = 0; k < 16; k++) begin
      set_code(k[3:0]);
      #10;
      check_val($sformatf("sweep_f_%0d", k), {15'd0, f}, {15'd0, exp_prime[k]});
      check_val($sformatf("sweep_f2_%0d", k), {15'd0, f2}, {15'd0, exp_ends[k]});
    end

    @(negedge clk);
    rst = 1'b0;
    set_code(4'd3);
    tick();
    check_val("reg_rise_q", {15'd0, f_q}, 16'd1);
    check_val("reg_rise_pulse", {14'd0, f_rise, f_fall}, 16'b10);
    tick();
    check_val("reg_hold_q", {15'd0, f_q}, 16'd1);
    check_val("reg_hold_pulse", {14'd0, f_rise, f_fall}, 16'b00);
    @(negedge clk);
    set_code(4'd4);
    tick();
    check_val("reg_fall_q", {15'd0, f_q}, 16'd0);
    check_val("reg_fall_pulse", {14'd0, f_rise, f_fall}, 16'b01);
    tick();
    check_val("reg_fall_end", {14'd0, f_rise, f_fall}, 16'b00);

    // toggling every cycle keeps the pulses alternating
    @(negedge clk);
    set_code(4'd13);
    tick();
    check_val("tog_rise", {13'd0, f_q, f_rise, f_fall}, 16'b110);
    @(negedge clk);
    set_code(4'd14);
    tick();
    check_val("tog_fall", {13'd0, f_q, f_rise, f_fall}, 16'b001);

    // async reset between edges right after a rising pulse
    @(negedge clk);
    set_code(4'd3);
    tick();
    check_val("pre_arst", {13'd0, f_q, f_rise, f_fall}, 16'b110);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_regs", {13'd0, f_q, f_rise, f_fall}, 16'b000);
    set_code(4'd5);
    #1;
    check_val("arst_f_5", {15'd0, f}, 16'd1);
    set_code(4'd4);
    #1;
    check_val("arst_f_4", {15'd0, f}, 16'd0);

    // coverage: codes 0..14, then 15
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      set_code(k[3:0]);
      @(posedge clk);
      @(negedge clk);
    end
    check_val("cov_mask_15", seen_mask, EXP_MASK_15);
    check_val("cov_all_15", {15'd0, all_seen}, 16'd0);
    set_code(4'd15);
    tick();
    check_val("cov_mask_16", seen_mask, EXP_MASK_16);
    check_val("cov_all_16", {15'd0, all_seen}, {15'd0, EXP_ALL_16});
    #2;
    rst = 1'b1;
    #1;
    check_val("cov_rst_mask", seen_mask, 16'h0000);
    check_val("cov_rst_all", {15'd0, all_seen}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
